// File: rtl/db_scan_sched_amisha_if.sv
// Switch-side bundle for the shared-timer debounce scheduler: raw switch inputs in,
// debounced levels, commit ticks and timer ownership out.
interface db_scan_sched_amisha_if #(
  parameter int NSW   = 4,
  parameter int IDX_W = 2
);
  logic [NSW-1:0]   sw_amisha;
  logic [NSW-1:0]   db_level_amisha;
  logic [NSW-1:0]   db_tick_amisha;
  logic             busy_amisha;
  logic [IDX_W-1:0] owner_amisha;

  modport master (
    output sw_amisha,
    input  db_level_amisha,
    input  db_tick_amisha,
    input  busy_amisha,
    input  owner_amisha
  );

  modport slave (
    input  sw_amisha,
    output db_level_amisha,
    output db_tick_amisha,
    output busy_amisha,
    output owner_amisha
  );
endinterface

// File: rtl/db_scan_sched_amisha.sv
// Debounce scheduler: one down-counter shared round-robin among NSW switches.
// Define DB_SCAN_SYNC_EN to add a two-flop synchronizer on every switch input.
module db_scan_sched_amisha #(
  parameter int NSW    = 4,
  parameter int CNT_W  = 21,
  parameter int DB_CNT = 2097151,
  parameter int IDX_W  = 2
) (
  input  logic                  clk_amisha,
  input  logic                  reset_amisha,
  db_scan_sched_amisha_if.slave bus
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] owner;
  logic [NSW-1:0]   db_level;
  logic [NSW-1:0]   db_tick;
  logic             busy;

  logic [NSW-1:0]   s;
  logic [NSW-1:0]   pend;
  logic             grant_vld;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] owner_nxt;

`ifdef DB_SCAN_SYNC_EN
  logic [NSW-1:0] sync_p0;
  logic [NSW-1:0] sync_p1;

  // Synchronizer stages p0 -> p1
  always_ff @(posedge clk_amisha) begin
    if (reset_amisha) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= bus.sw_amisha;
      sync_p1 <= sync_p0;
    end
  end

  assign s = sync_p1;
`else
  assign s = bus.sw_amisha;
`endif

  assign pend = s ^ db_level;

  // First pending switch at or after rr_ptr, wrapping at NSW.
  always_comb begin
    int j;
    logic [IDX_W-1:0] cand;
    grant_vld = 1'b0;
    grant_idx = '0;
    j         = 0;
    cand      = '0;
    for (int k = 0; k < NSW; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NSW) j = j - NSW;
      cand = IDX_W'(j);
      if (!grant_vld && pend[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign owner_nxt = (int'(owner) == NSW - 1) ? '0 : owner + 1'b1;

  always_ff @(posedge clk_amisha) begin
    if (reset_amisha) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      rr_ptr   <= '0;
      owner    <= '0;
      db_level <= '0;
      db_tick  <= '0;
      busy     <= 1'b0;
    end else begin
      db_tick <= '0;
      unique case (state)
        ST_IDLE: begin
          if (grant_vld) begin
            owner <= grant_idx;
            cnt   <= CNT_W'(DB_CNT);
            state <= ST_WAIT;
            busy  <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (s[owner] == db_level[owner]) begin
            // Owner bounced back before the count expired: release the timer untouched.
            state  <= ST_IDLE;
            busy   <= 1'b0;
            cnt    <= '0;
            rr_ptr <= owner_nxt;
          end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            db_level[owner] <= ~db_level[owner];
            if (!db_level[owner]) db_tick[owner] <= 1'b1;
            rr_ptr <= owner_nxt;
            state  <= ST_IDLE;
            busy   <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.db_level_amisha = db_level;
  assign bus.db_tick_amisha  = db_tick;
  assign bus.busy_amisha     = busy;
  assign bus.owner_amisha    = owner;

endmodule

// File: tb/tb_db_scan_sched_amisha.sv
// Directed bench for db_scan_sched_amisha with NSW=4, DB_CNT=4, synchronizer disabled.
module tb_db_scan_sched_amisha;

  logic clk_amisha   = 1'b0;
  logic reset_amisha = 1'b1;

  always #5 clk_amisha = ~clk_amisha;

  db_scan_sched_amisha_if #(.NSW(4), .IDX_W(2)) bus ();

  db_scan_sched_amisha #(
    .NSW(4), .CNT_W(4), .DB_CNT(4), .IDX_W(2)
  ) dut (
    .clk_amisha  (clk_amisha),
    .reset_amisha(reset_amisha),
    .bus         (bus.slave)
  );

  typedef struct {
    logic [3:0] sw;
    logic [3:0] lvl;
    logic [3:0] tick;
    logic       busy;
    logic [1:0] owner;
  } vec_t;

  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;

  function automatic void add(input logic [3:0] sw, input logic [3:0] lvl,
                              input logic [3:0] tick, input logic busy,
                              input logic [1:0] owner);
    vec_t v;
    v.sw = sw; v.lvl = lvl; v.tick = tick; v.busy = busy; v.owner = owner;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare all outputs at the falling edge; owner only matters while busy.
  task automatic chk_all(input string tag, input logic [3:0] lvl, input logic [3:0] tick,
                         input logic busy, input logic [1:0] owner);
    @(negedge clk_amisha);
    chk({tag, " level"}, 32'(bus.db_level_amisha), 32'(lvl));
    chk({tag, " tick"},  32'(bus.db_tick_amisha),  32'(tick));
    chk({tag, " busy"},  32'(bus.busy_amisha),     32'(busy));
    if (busy) chk({tag, " owner"}, 32'(bus.owner_amisha), 32'(owner));
  endtask

  task automatic step();
    @(posedge clk_amisha);
    #1;
  endtask

  task automatic do_reset();
    reset_amisha  = 1'b1;
    bus.sw_amisha = 4'b0000;
    repeat (2) step();
    chk_all("reset", 4'b0000, 4'b0000, 1'b0, 2'd0);
    reset_amisha = 1'b0;
    step();
  endtask

  initial begin
    // Commit 0->1 on switch 0
    add(4'h1, 4'h0, 4'h0, 0, 0);
    for (int i = 0; i < 5; i++) add(4'h1, 4'h0, 4'h0, 1, 0);
    add(4'h1, 4'h1, 4'h1, 0, 0);
    add(4'h1, 4'h1, 4'h0, 0, 0);
    // Commit 1->0 on switch 0, no tick
    add(4'h0, 4'h1, 4'h0, 0, 0);
    for (int i = 0; i < 5; i++) add(4'h0, 4'h1, 4'h0, 1, 0);
    add(4'h0, 4'h0, 4'h0, 0, 0);
    // Switch 1 bounces back: abort, rr_ptr moves to 2
    add(4'h2, 4'h0, 4'h0, 0, 0);
    add(4'h2, 4'h0, 4'h0, 1, 1);
    add(4'h2, 4'h0, 4'h0, 1, 1);
    add(4'h0, 4'h0, 4'h0, 1, 1);
    add(4'h0, 4'h0, 4'h0, 0, 0);
    // Switches 0,1 pending with rr_ptr=2: 0 wins, then 1
    add(4'h3, 4'h0, 4'h0, 0, 0);
    for (int i = 0; i < 5; i++) add(4'h3, 4'h0, 4'h0, 1, 0);
    add(4'h3, 4'h1, 4'h1, 0, 0);
    for (int i = 0; i < 5; i++) add(4'h3, 4'h1, 4'h0, 1, 1);
    add(4'h3, 4'h3, 4'h2, 0, 0);
    add(4'h3, 4'h3, 4'h0, 0, 0);

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      bus.sw_amisha = tbl[i].sw;
      chk_all($sformatf("vec%0d", i), tbl[i].lvl, tbl[i].tick, tbl[i].busy, tbl[i].owner);
      step();
    end

    // Two simultaneous requests: 0 commits first, then 2 is granted in the IDLE cycle
    do_reset();
    bus.sw_amisha = 4'b0101;
    chk_all("dual c0", 4'h0, 4'h0, 0, 0);
    step();
    chk_all("dual c1", 4'h0, 4'h0, 1, 0);
    repeat (5) step();
    chk_all("dual c6", 4'h1, 4'h1, 0, 0);
    step();
    chk_all("dual c7", 4'h1, 4'h0, 1, 2);
    repeat (5) step();
    chk_all("dual c12", 4'h5, 4'h4, 0, 0);
    step();
    chk_all("dual c13", 4'h5, 4'h0, 0, 0);

    // After switch 0 commits, 0 and 1 pend together: rr_ptr=1 grants 1
    do_reset();
    bus.sw_amisha = 4'b0001;
    repeat (6) step();
    chk_all("rr c6", 4'h1, 4'h1, 0, 0);
    bus.sw_amisha = 4'b0010;
    step();
    chk_all("rr c7", 4'h1, 4'h0, 1, 1);

    // Reset in the middle of a WAIT kills the pending commit
    do_reset();
    bus.sw_amisha = 4'b0001;
    repeat (3) step();
    reset_amisha = 1'b1;
    chk_all("mid c3", 4'h0, 4'h0, 1, 0);
    step();
    reset_amisha = 1'b0;
    chk_all("mid c4", 4'h0, 4'h0, 0, 0);
    for (int c = 5; c < 10; c++) begin
      step();
      chk_all($sformatf("mid c%0d", c), 4'h0, 4'h0, 1, 0);
    end
    step();
    chk_all("mid c10", 4'h1, 4'h1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
